// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues word fetches, tags each grant with its address,
// buffers returned words for the decoder and discards in-flight fetches on redirect.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    output logic        inst_valid,
    input  logic        inst_ready
);
    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PZERO_C = {PW{1'b0}};
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);
    localparam logic [31:0]   NOP_C   = 32'h0000_0013;
    localparam logic [31:0]   ALIGN_C = 32'hFFFF_FFFC;

    typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_e;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? PZERO_C : p + {{(PW-1){1'b0}}, 1'b1};
    endfunction

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   tag_q [DEPTH];
    logic [PW-1:0] tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [31:0]   fifo_inst_q [DEPTH];
    logic [31:0]   fifo_addr_q [DEPTH];
    logic [PW-1:0] fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0] disc_q, disc_d;
    logic          valid_q, valid_d;
    logic          req_s, gnt_s, rsp_s, pop_s, tag_push_s, fifo_push_s;
    logic [CW:0]   occ_s;

    // Occupancy counts the slot freed by this cycle's handshake so a single-cycle
    // memory sustains one instruction per cycle.
    assign occ_s = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q} - {{CW{1'b0}}, pop_s};
    assign req_s = !rst && (state_q == RUN) && !redirect && (occ_s < {1'b0, DEPTH_C});
    assign gnt_s = req_s && imem_gnt;
    assign rsp_s = imem_rvalid && (out_cnt_q != ZERO_C) && (state_q == RUN);
    assign pop_s = valid_q && inst_ready;

    // Next-state logic for fetch PC, tag queue, instruction FIFO and flush control.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tag_wp_d    = tag_wp_q;
        tag_rp_d    = tag_rp_q;
        out_cnt_d   = out_cnt_q;
        fifo_wp_d   = fifo_wp_q;
        fifo_rp_d   = fifo_rp_q;
        fifo_cnt_d  = fifo_cnt_q;
        disc_d      = disc_q;
        tag_push_s  = 1'b0;
        fifo_push_s = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect) begin
                    pc_d       = redirect_pc & ALIGN_C;
                    tag_wp_d   = PZERO_C;
                    tag_rp_d   = PZERO_C;
                    out_cnt_d  = ZERO_C;
                    fifo_wp_d  = PZERO_C;
                    fifo_rp_d  = PZERO_C;
                    fifo_cnt_d = ZERO_C;
                    // A response arriving with the redirect is dropped now, not counted.
                    disc_d     = out_cnt_q + CW'(gnt_s) - CW'(rsp_s);
                    state_d    = (disc_d != ZERO_C) ? FLUSH : RUN;
                end else begin
                    tag_push_s  = gnt_s;
                    fifo_push_s = rsp_s;
                    if (gnt_s) begin
                        pc_d     = pc_q + 32'd4;
                        tag_wp_d = ptr_inc(tag_wp_q);
                    end else begin
                        pc_d     = pc_q;
                        tag_wp_d = tag_wp_q;
                    end
                    if (rsp_s) begin
                        tag_rp_d  = ptr_inc(tag_rp_q);
                        fifo_wp_d = ptr_inc(fifo_wp_q);
                    end else begin
                        tag_rp_d  = tag_rp_q;
                        fifo_wp_d = fifo_wp_q;
                    end
                    if (pop_s) begin
                        fifo_rp_d = ptr_inc(fifo_rp_q);
                    end else begin
                        fifo_rp_d = fifo_rp_q;
                    end
                    out_cnt_d  = out_cnt_q + CW'(gnt_s) - CW'(rsp_s);
                    fifo_cnt_d = fifo_cnt_q + CW'(rsp_s) - CW'(pop_s);
                end
            end
            FLUSH: begin
                if (redirect) begin
                    pc_d = redirect_pc & ALIGN_C;
                end else begin
                    pc_d = pc_q;
                end
                if (imem_rvalid && (disc_q != ZERO_C)) begin
                    disc_d = disc_q - ONE_C;
                end else begin
                    disc_d = disc_q;
                end
                if (disc_d == ZERO_C) begin
                    state_d = RUN;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign valid_d = (fifo_cnt_d != ZERO_C);

    // Control and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            tag_wp_q   <= PZERO_C;
            tag_rp_q   <= PZERO_C;
            out_cnt_q  <= ZERO_C;
            fifo_wp_q  <= PZERO_C;
            fifo_rp_q  <= PZERO_C;
            fifo_cnt_q <= ZERO_C;
            disc_q     <= ZERO_C;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tag_wp_q   <= tag_wp_d;
            tag_rp_q   <= tag_rp_d;
            out_cnt_q  <= out_cnt_d;
            fifo_wp_q  <= fifo_wp_d;
            fifo_rp_q  <= fifo_rp_d;
            fifo_cnt_q <= fifo_cnt_d;
            disc_q     <= disc_d;
            valid_q    <= valid_d;
        end
    end

    // Tag queue and instruction FIFO storage; FIFO resets to NOP at address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]       <= 32'h0000_0000;
                fifo_inst_q[i] <= NOP_C;
                fifo_addr_q[i] <= 32'h0000_0000;
            end
        end else begin
            if (tag_push_s) begin
                tag_q[tag_wp_q] <= pc_q;
            end
            if (fifo_push_s) begin
                fifo_inst_q[fifo_wp_q] <= imem_rdata;
                fifo_addr_q[fifo_wp_q] <= tag_q[tag_rp_q];
            end
        end
    end

    assign imem_req   = req_s;
    assign imem_addr  = pc_q;
    assign inst       = fifo_inst_q[fifo_rp_q];
    assign inst_addr  = fifo_addr_q[fifo_rp_q];
    assign inst_valid = valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: memory model with a response queue and a
// scoreboard of expected {addr, word} pairs popped on each decoder handshake.
module tb_inst_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          ep;
    } pend_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_valid;
    logic        inst_ready = 1'b0;

    int          total = 0;
    int          bad = 0;
    int          ngrant = 0;
    int          cur_ep = 0;
    int          rsp_ep = 0;
    logic        rsp_en = 1'b0;
    logic [31:0] rsp_addr = 32'h0;
    logic [31:0] pc_model = RST_PC;
    logic        last_req, last_v, last_g;
    logic [31:0] last_addr, last_inst, last_inst_addr;
    pend_t       pend_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] gaddr_q[$];

    inst_fetch #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst(inst), .inst_addr(inst_addr), .inst_valid(inst_valid), .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // One clock: sample at negedge, update models, then drive memory response after the edge.
    task automatic step();
        pend_t p;
        logic [63:0] e;
        @(negedge clk);
        last_req = imem_req; last_addr = imem_addr; last_v = inst_valid;
        last_inst = inst; last_inst_addr = inst_addr;
        last_g = imem_req && imem_gnt && !rst;
        if (!rst) begin
            if (redirect) begin
                total++;
                if (imem_req !== 1'b0) begin
                    bad++; $display("FAIL req_during_redirect: got %b want 0", imem_req);
                end
            end
            if (last_g) begin
                total++;
                if (imem_addr !== pc_model) begin
                    bad++; $display("FAIL fetch_addr: got %h want %h", imem_addr, pc_model);
                end
                gaddr_q.push_back(imem_addr);
                p.addr = pc_model; p.ep = cur_ep;
                pend_q.push_back(p);
                pc_model = pc_model + 32'd4;
                ngrant++;
            end
            if (inst_valid && inst_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL unexpected_inst: got addr %h inst %h want none", inst_addr, inst);
                end else begin
                    e = exp_q.pop_front();
                    if ({inst_addr, inst} !== e) begin
                        bad++; $display("FAIL inst_word: got %h/%h want %h/%h", inst_addr, inst, e[63:32], e[31:0]);
                    end
                end
            end
            if (imem_rvalid && rsp_ep == cur_ep && !redirect) exp_q.push_back({rsp_addr, word(rsp_addr)});
            if (redirect) begin
                pc_model = {redirect_pc[31:2], 2'b00};
                cur_ep++;
                exp_q.delete();
            end
        end
        @(posedge clk);
        #1;
        redirect = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        if (rsp_en && pend_q.size() != 0) begin
            p = pend_q.pop_front();
            imem_rvalid = 1'b1; imem_rdata = word(p.addr);
            rsp_addr = p.addr; rsp_ep = p.ep;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; imem_gnt = 1'b0; inst_ready = 1'b0; rsp_en = 1'b0;
        imem_rvalid = 1'b0;
        pend_q.delete(); exp_q.delete(); cur_ep++; pc_model = RST_PC;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        imem_gnt = 1'b0; rsp_en = 1'b1; inst_ready = 1'b1;
        while ((exp_q.size() != 0 || pend_q.size() != 0 || imem_rvalid) && n < 40) begin
            step(); n++;
        end
        step();
        total++;
        if (exp_q.size() != 0 || last_v !== 1'b0) begin
            bad++; $display("FAIL %s_drain: got %0d pending words valid=%b want 0 and 0", name, exp_q.size(), last_v);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; #1; rst = 1'b1; #1;
        total += 5;
        if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        if (imem_addr !== RST_PC) begin bad++; $display("FAIL reset_addr: got %h want %h", imem_addr, RST_PC); end
        if (inst !== 32'h0000_0013) begin bad++; $display("FAIL reset_inst: got %h want 00000013", inst); end
        if (inst_addr !== 32'h0) begin bad++; $display("FAIL reset_inst_addr: got %h want 0", inst_addr); end
        if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        int fg = -1, fv = -1, vcnt = 0;
        do_reset();
        imem_gnt = 1'b1; rsp_en = 1'b1; inst_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            if (last_g && fg < 0) fg = i;
            if (last_v) begin
                if (fv < 0) fv = i;
                vcnt++;
            end
        end
        total += 2;
        if (fv - fg != 2) begin bad++; $display("FAIL stream_latency: got %0d want 2", fv - fg); end
        if (vcnt != 14 - fv) begin bad++; $display("FAIL stream_throughput: got %0d want %0d", vcnt, 14 - fv); end
        drain("stream");
    endtask

    task automatic test_stall();
        int g0, vc = 0;
        do_reset();
        imem_gnt = 1'b1; rsp_en = 1'b1; inst_ready = 1'b0;
        g0 = ngrant;
        for (int i = 0; i < 5; i++) begin
            step();
            if (last_v) begin
                vc++;
                total++;
                if (last_inst_addr !== RST_PC || last_inst !== word(RST_PC)) begin
                    bad++; $display("FAIL stall_hold: got %h/%h want %h/%h", last_inst_addr, last_inst, RST_PC, word(RST_PC));
                end
            end
        end
        total += 3;
        if (ngrant - g0 != 2) begin bad++; $display("FAIL stall_grants: got %0d want 2", ngrant - g0); end
        if (last_req !== 1'b0) begin bad++; $display("FAIL stall_req: got %b want 0", last_req); end
        if (vc != 3) begin bad++; $display("FAIL stall_valid_cycles: got %0d want 3", vc); end
        inst_ready = 1'b1;
        repeat (4) step();
        drain("stall");
    endtask

    task automatic test_flush();
        int g0;
        do_reset();
        imem_gnt = 1'b1; inst_ready = 1'b1; rsp_en = 1'b0;
        g0 = ngrant;
        step(); step();
        total++;
        if (ngrant - g0 != 2) begin bad++; $display("FAIL flush_setup_grants: got %0d want 2", ngrant - g0); end
        redirect = 1'b1; redirect_pc = 32'h0000_0100; rsp_en = 1'b1;
        step();
        step();
        total += 2;
        if (last_req !== 1'b0) begin bad++; $display("FAIL flush_req1: got %b want 0", last_req); end
        if (last_v !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", last_v); end
        step();
        total++;
        if (last_req !== 1'b0) begin bad++; $display("FAIL flush_req2: got %b want 0", last_req); end
        step();
        total++;
        if (last_req !== 1'b1 || last_addr !== 32'h0000_0100) begin
            bad++; $display("FAIL flush_resume: got req=%b addr=%h want 1 00000100", last_req, last_addr);
        end
        drain("flush");
    endtask

    task automatic test_redirect_hs();
        do_reset();
        imem_gnt = 1'b1; rsp_en = 1'b1; inst_ready = 1'b1;
        repeat (6) step();
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        total++;
        if (last_v !== 1'b1) begin bad++; $display("FAIL rhs_valid_at_redirect: got %b want 1", last_v); end
        step();
        total += 2;
        if (last_v !== 1'b0) begin bad++; $display("FAIL rhs_valid_after: got %b want 0", last_v); end
        if (last_req !== 1'b1 || last_addr !== 32'h0000_0200) begin
            bad++; $display("FAIL rhs_resume: got req=%b addr=%h want 1 00000200", last_req, last_addr);
        end
        drain("rhs");
    endtask

    task automatic test_wrap();
        do_reset();
        imem_gnt = 1'b1; rsp_en = 1'b1; inst_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        step();
        gaddr_q.delete();
        step(); step();
        total++;
        if (gaddr_q.size() < 2) begin
            bad++; $display("FAIL wrap_grants: got %0d want 2", gaddr_q.size());
        end else begin
            total++;
            if (gaddr_q[0] !== 32'hFFFF_FFFC || gaddr_q[1] !== 32'h0000_0000) begin
                bad++; $display("FAIL wrap_addrs: got %h %h want fffffffc 00000000", gaddr_q[0], gaddr_q[1]);
            end
        end
        drain("wrap");
    endtask

    task automatic test_mid_reset();
        do_reset();
        imem_gnt = 1'b1; inst_ready = 1'b1; rsp_en = 1'b0;
        step(); step();
        rst = 1'b1; #2;
        total += 4;
        if (imem_req !== 1'b0) begin bad++; $display("FAIL mrst_req: got %b want 0", imem_req); end
        if (imem_addr !== RST_PC) begin bad++; $display("FAIL mrst_addr: got %h want %h", imem_addr, RST_PC); end
        if (inst_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid: got %b want 0", inst_valid); end
        if (inst !== 32'h0000_0013) begin bad++; $display("FAIL mrst_inst: got %h want 00000013", inst); end
        exp_q.delete(); cur_ep++; pc_model = RST_PC;
        imem_gnt = 1'b0; rsp_en = 1'b1;
        step(); step();
        rst = 1'b0;
        step(); step();
        total++;
        if (last_v !== 1'b0) begin bad++; $display("FAIL mrst_spurious: got valid %b want 0", last_v); end
        imem_gnt = 1'b1;
        step();
        total++;
        if (last_g !== 1'b1 || last_addr !== RST_PC) begin
            bad++; $display("FAIL mrst_restart: got gnt=%b addr=%h want 1 %h", last_g, last_addr, RST_PC);
        end
        drain("mrst");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_redirect_hs();
        test_wrap();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
